// File: rtl/uart_cmd_parser.sv
// ASCII command-line parser between the UART RX FIFO and the PWM core.
// Accepts "F<dec>" / "D<dec>" lines and drives the PWM configuration registers.
module uart_cmd_parser #(
  parameter int DEFAULT_FREQ_HZ = 1000,
  parameter int DEFAULT_DUTY    = 50,
  parameter int MAX_FREQ_HZ     = 1_000_000,
  parameter int MAX_DIGITS      = 7
) (
  input  logic        clk_50mhz,
  input  logic        rst,
  input  logic [7:0]  fifo_data,
  input  logic        fifo_empty,
  input  logic        eos_flag,
  output logic        fifo_read,
  output logic [23:0] freq_hz,
  output logic [6:0]  duty_pct,
  output logic        cfg_update,
  output logic        cmd_error,
  output logic [1:0]  err_code,
  output logic        busy
);

  typedef enum logic [1:0] {S_CMD, S_DIGITS, S_FLUSH, S_CHECK} state_t;

  localparam logic [1:0] E_SYNTAX = 2'd0;
  localparam logic [1:0] E_RANGE  = 2'd1;
  localparam logic [1:0] E_DIGITS = 2'd2;
  localparam logic [1:0] E_EMPTY  = 2'd3;

  state_t      state;
  logic        is_freq;
  logic [27:0] acc;
  logic [3:0]  ndig;
  logic        eos_d;
  logic        pop_d;
  logic        eos_rise;
  logic        pop;
  logic        is_term;
  logic        is_digit;
  logic        is_f;
  logic        is_d;
  logic [27:0] acc_next;

  assign eos_rise = eos_flag & ~eos_d;
  assign is_term  = (fifo_data == 8'h0D) || (fifo_data == 8'h0A);
  assign is_digit = (fifo_data >= 8'h30) && (fifo_data <= 8'h39);
  assign is_f     = (fifo_data == 8'h46) || (fifo_data == 8'h66);
  assign is_d     = (fifo_data == 8'h44) || (fifo_data == 8'h64);
  // ASCII '0'..'9' carry the digit value in the low nibble
  assign acc_next = (acc << 3) + (acc << 1) + {24'd0, fifo_data[3:0]};
  assign busy     = (state != S_CMD);
  assign fifo_read = pop;

  // Pop at most every other cycle; an eos rise suppresses the pop so the
  // next line's first byte is not swallowed while the current line closes.
  always_comb begin
    pop = 1'b0;
    if (!fifo_empty && !pop_d) begin
      case (state)
        S_CMD:             pop = 1'b1;
        S_DIGITS, S_FLUSH: pop = ~eos_rise;
        default:           pop = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk_50mhz) begin
    if (rst) begin
      state      <= S_CMD;
      is_freq    <= 1'b0;
      acc        <= '0;
      ndig       <= '0;
      eos_d      <= 1'b0;
      pop_d      <= 1'b0;
      freq_hz    <= 24'(DEFAULT_FREQ_HZ);
      duty_pct   <= 7'(DEFAULT_DUTY);
      cfg_update <= 1'b0;
      cmd_error  <= 1'b0;
      err_code   <= E_SYNTAX;
    end else begin
      eos_d      <= eos_flag;
      pop_d      <= pop;
      cfg_update <= 1'b0;
      cmd_error  <= 1'b0;
      case (state)
        S_CMD: begin
          if (pop) begin
            if (is_f || is_d) begin
              is_freq <= is_f;
              acc     <= '0;
              ndig    <= '0;
              state   <= S_DIGITS;
            end else if (!is_term) begin
              cmd_error <= 1'b1;
              err_code  <= E_SYNTAX;
              state     <= S_FLUSH;
            end
          end
        end
        S_DIGITS: begin
          if (eos_rise) begin
            state <= S_CHECK;
          end else if (pop) begin
            if (is_digit) begin
              if (ndig == 4'(MAX_DIGITS)) begin
                cmd_error <= 1'b1;
                err_code  <= E_DIGITS;
                state     <= S_FLUSH;
              end else begin
                acc  <= acc_next;
                ndig <= ndig + 4'd1;
              end
            end else if (is_term) begin
              state <= S_CHECK;
            end else begin
              cmd_error <= 1'b1;
              err_code  <= E_SYNTAX;
              state     <= S_FLUSH;
            end
          end
        end
        S_FLUSH: begin
          if (eos_rise || (pop && is_term))
            state <= S_CMD;
        end
        S_CHECK: begin
          state <= S_CMD;
          if (ndig == 4'd0) begin
            cmd_error <= 1'b1;
            err_code  <= E_EMPTY;
          end else if (is_freq) begin
            if (acc == 28'd0 || acc > 28'(MAX_FREQ_HZ)) begin
              cmd_error <= 1'b1;
              err_code  <= E_RANGE;
            end else begin
              freq_hz    <= acc[23:0];
              cfg_update <= 1'b1;
            end
          end else begin
            if (acc > 28'd100) begin
              cmd_error <= 1'b1;
              err_code  <= E_RANGE;
            end else begin
              duty_pct   <= acc[6:0];
              cfg_update <= 1'b1;
            end
          end
        end
        default: state <= S_CMD;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser: a queue models the RX FIFO and a table of
// command lines carries the expected register / pulse / error state after each.
module tb_uart_cmd_parser;

  logic        clk_50mhz = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  fifo_data = 8'h00;
  logic        fifo_empty = 1'b1;
  logic        eos_flag = 1'b0;
  logic        fifo_read;
  logic [23:0] freq_hz;
  logic [6:0]  duty_pct;
  logic        cfg_update;
  logic        cmd_error;
  logic [1:0]  err_code;
  logic        busy;

  uart_cmd_parser dut (
    .clk_50mhz (clk_50mhz),
    .rst       (rst),
    .fifo_data (fifo_data),
    .fifo_empty(fifo_empty),
    .eos_flag  (eos_flag),
    .fifo_read (fifo_read),
    .freq_hz   (freq_hz),
    .duty_pct  (duty_pct),
    .cfg_update(cfg_update),
    .cmd_error (cmd_error),
    .err_code  (err_code),
    .busy      (busy)
  );

  always #5 clk_50mhz = ~clk_50mhz;

  typedef struct packed {
    logic [95:0] txt;
    logic [23:0] freq;
    logic [6:0]  duty;
    logic [3:0]  ncfg;
    logic [3:0]  nerr;
    logic [1:0]  code;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs[NV];

  byte q[$];
  int  n_chk = 0, n_fail = 0;
  int  cyc = 0, n_cfg = 0, n_err = 0, b2b = 0, both = 0;
  int  term_cyc = 0, cfg_cyc = 0;
  logic prev_rd = 1'b0;

  task automatic refresh();
    fifo_empty = (q.size() == 0);
    fifo_data  = (q.size() == 0) ? 8'h00 : q[0];
  endtask

  // FIFO model and pulse monitor: sample pre-edge values, pop just after the edge
  always @(posedge clk_50mhz) begin
    logic rd;
    logic [7:0] d;
    cyc++;
    rd = fifo_read;
    d  = fifo_data;
    if (cfg_update) begin n_cfg++; cfg_cyc = cyc; end
    if (cmd_error) n_err++;
    if (cfg_update && cmd_error) both++;
    if (rd && prev_rd) b2b++;
    prev_rd = rd;
    if (rd && (d == 8'h0A || d == 8'h0D)) term_cyc = cyc;
    #1;
    if (rd && q.size() > 0) void'(q.pop_front());
    refresh();
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_txt(input logic [95:0] txt);
    logic [95:0] t;
    t = txt;
    @(negedge clk_50mhz);
    for (int b = 11; b >= 0; b--)
      if (t[b*8 +: 8] != 8'h00) q.push_back(t[b*8 +: 8]);
    refresh();
  endtask

  task automatic wait_idle(input string name);
    for (int k = 0; k < 400; k++) begin
      @(negedge clk_50mhz);
      if (q.size() == 0 && !busy) begin
        repeat (3) @(negedge clk_50mhz);
        return;
      end
    end
    n_chk++;
    n_fail++;
    $display("FAIL %s: timeout waiting for idle, busy=%0d fifo_left=%0d", name, busy, q.size());
  endtask

  task automatic clr_counts();
    n_cfg = 0;
    n_err = 0;
  endtask

  initial begin
    vecs[0]  = '{"F2500\n",     24'd2500,    7'd50,  4'd1, 4'd0, 2'd0};
    vecs[1]  = '{"D101\r",      24'd2500,    7'd50,  4'd0, 4'd1, 2'd1};
    vecs[2]  = '{"D0\n",        24'd2500,    7'd0,   4'd1, 4'd0, 2'd1};
    vecs[3]  = '{"X12\nD75\n",  24'd2500,    7'd75,  4'd1, 4'd1, 2'd0};
    vecs[4]  = '{"F12345678\n", 24'd2500,    7'd75,  4'd0, 4'd1, 2'd2};
    vecs[5]  = '{"F\n",         24'd2500,    7'd75,  4'd0, 4'd1, 2'd3};
    vecs[6]  = '{"F1000000\n",  24'd1000000, 7'd75,  4'd1, 4'd0, 2'd3};
    vecs[7]  = '{"F1000001\n",  24'd1000000, 7'd75,  4'd0, 4'd1, 2'd1};
    vecs[8]  = '{"F0\n",        24'd1000000, 7'd75,  4'd0, 4'd1, 2'd1};
    vecs[9]  = '{"D100\r",      24'd1000000, 7'd100, 4'd1, 4'd0, 2'd1};
    vecs[10] = '{"\r\n",        24'd1000000, 7'd100, 4'd0, 4'd0, 2'd1};
    vecs[11] = '{"f42\n",       24'd42,      7'd100, 4'd1, 4'd0, 2'd1};
    vecs[12] = '{"d7x\n",       24'd42,      7'd100, 4'd0, 4'd1, 2'd0};
    vecs[13] = '{"F00000001\n", 24'd42,      7'd100, 4'd0, 4'd1, 2'd2};
    vecs[14] = '{"d09\n",       24'd42,      7'd9,   4'd1, 4'd0, 2'd2};

    // reset state
    repeat (3) @(negedge clk_50mhz);
    chk("rst_freq", int'(freq_hz), 1000);
    chk("rst_duty", int'(duty_pct), 50);
    chk("rst_read", int'(fifo_read), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_cfg",  int'(cfg_update), 0);
    chk("rst_err",  int'(cmd_error), 0);
    chk("rst_code", int'(err_code), 0);
    rst = 1'b0;
    @(negedge clk_50mhz);
    clr_counts();

    for (int i = 0; i < NV; i++) begin
      clr_counts();
      push_txt(vecs[i].txt);
      wait_idle($sformatf("v%0d_idle", i));
      chk($sformatf("v%0d_freq", i), int'(freq_hz), int'(vecs[i].freq));
      chk($sformatf("v%0d_duty", i), int'(duty_pct), int'(vecs[i].duty));
      chk($sformatf("v%0d_ncfg", i), n_cfg, int'(vecs[i].ncfg));
      chk($sformatf("v%0d_nerr", i), n_err, int'(vecs[i].nerr));
      chk($sformatf("v%0d_code", i), int'(err_code), int'(vecs[i].code));
      if (vecs[i].ncfg == 4'd1)
        chk($sformatf("v%0d_latency", i), cfg_cyc - term_cyc, 2);
    end
    chk("no_b2b_pops", b2b, 0);
    chk("cfg_err_overlap", both, 0);

    // eos rise terminates "F900" with no terminator byte
    clr_counts();
    push_txt("F900");
    repeat (12) @(negedge clk_50mhz);
    chk("eos_busy_before", int'(busy), 1);
    chk("eos_freq_before", int'(freq_hz), 42);
    eos_flag = 1'b1;
    repeat (3) @(negedge clk_50mhz);
    eos_flag = 1'b0;
    repeat (2) @(negedge clk_50mhz);
    chk("eos_freq", int'(freq_hz), 900);
    chk("eos_ncfg", n_cfg, 1);
    chk("eos_busy_after", int'(busy), 0);
    // a second rise while idle is ignored
    eos_flag = 1'b1;
    repeat (3) @(negedge clk_50mhz);
    eos_flag = 1'b0;
    repeat (2) @(negedge clk_50mhz);
    chk("eos_idle_nerr", n_err, 0);
    chk("eos_idle_ncfg", n_cfg, 1);

    // reset in the middle of "D6"
    push_txt("D6");
    @(negedge clk_50mhz);
    chk("mid_busy", int'(busy), 1);
    rst = 1'b1;
    q.delete();
    refresh();
    repeat (2) @(negedge clk_50mhz);
    chk("mid_rst_freq", int'(freq_hz), 1000);
    chk("mid_rst_duty", int'(duty_pct), 50);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_code", int'(err_code), 0);
    chk("mid_rst_read", int'(fifo_read), 0);
    rst = 1'b0;
    @(negedge clk_50mhz);
    clr_counts();
    push_txt("D33\n");
    wait_idle("post_rst_idle");
    chk("post_rst_duty", int'(duty_pct), 33);
    chk("post_rst_ncfg", n_cfg, 1);
    chk("final_b2b", b2b, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
